image_frame_feeder: RTL
=======================

# image_frame_feeder

Double-buffered frame feeder sitting directly upstream of `CNN_top`. Accepts a pixel stream from the host side (valid/ready, one pixel per cycle), holds up to two complete 28×28 frames in ping-pong banks, and streams a committed frame into `CNN_top.din`. Frame transfer is paced by the network's `din_ready`, and the block asserts `start` until `conv1_done` releases the bank.

## Interface
Parameters:
- `PIX_W`, 8, input pixel width (unsigned).
- `FRAME_LEN`, 784, pixels per frame.
- `DOUT_W`, 32, width of `dout` (signed).
- `THRESH`, 128, binarization threshold; only used when `FEEDER_BINARIZE_EN` is defined.

Ports:
- `clk`, in, 1, single clock; all logic on the rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `s_valid`, in, 1, host pixel valid.
- `s_ready`, out, 1, feeder can accept a pixel.
- `s_data`, in, `PIX_W`, pixel value.
- `s_last`, in, 1, marks the final pixel of a frame.
- `din_ready`, in, 1, network requests the next word this cycle (drives `CNN_top.din_ready`).
- `dout`, out, `DOUT_W`, signed pixel word to `CNN_top.din`.
- `start`, out, 1, frame available; held until `conv1_done`.
- `conv1_done`, in, 1, network has finished consuming the frame.
- `frame_err`, out, 1, one-cycle pulse on a frame-length violation.
- `frames_sent`, out, 16, count of frames released; wraps at 65535→0.

## Operation
- Two banks, each holding `FRAME_LEN` entries, with flags `full[1:0]`, write pointer bank `wb` and read pointer bank `rb`, both reset to 0.
- Write side:
  - `s_ready = !full[wb]`. A pixel is accepted when `s_valid && s_ready`, stored at `wcnt`, and `wcnt` increments.
  - If the accepted pixel has `wcnt == FRAME_LEN-1`, the frame commits: `full[wb]<=1`, `wb` toggles, `wcnt<=0`.
  - If `s_last` is not set on that pixel, `frame_err` pulses, but the frame is still committed.
  - If `s_last` arrives with `wcnt < FRAME_LEN-1`, the partial frame is discarded: `wcnt<=0`, no commit, and `frame_err` pulses.
- Read FSM has three states:
  - `R_IDLE`: if `full[rb]`, set `start<=1`, `rcnt<=0`, and go to `R_STREAM`.
  - `R_STREAM`: on each cycle with `din_ready=1`, `dout<=word(bank[rb][rcnt])` and `rcnt++`. After the word with `rcnt == FRAME_LEN-1` is issued, go to `R_WAIT`. Cycles with `din_ready=0` hold `dout` and `rcnt`.
  - `R_WAIT`: `din_ready` cycles drive `dout<=0` (padding). On `conv1_done=1`: `start<=0`, `full[rb]<=0`, `rb` toggles, `frames_sent++`, and go to `R_IDLE`.
  - `conv1_done` seen in `R_STREAM` is an early release. The same actions as in `R_WAIT` apply, and the unread remainder is dropped.
- A write commit and a read release on the same cycle to different banks both take effect. They can never target the same bank, because `full` gates the write side.
- Reset, at any time, forces the following:
  - Outputs: `start=0`, `dout=0`, `s_ready=1`, `frame_err=0`, `frames_sent=0`.
  - Internal state: both `full` flags 0, `wcnt=rcnt=0`, FSM to `R_IDLE`.
  - Any in-flight frames are lost.

## Timing
- Write to start: a frame committed at edge N makes `start=1` after edge N+1, provided the FSM is idle and the bank is `rb`.
- Read latency is 1 cycle: `din_ready` sampled high at edge N produces the new `dout` valid after edge N, and `CNN_top` captures it at edge N+1.
- Throughput is one pixel per cycle on both sides, and the two sides run concurrently on different banks.
- Backpressure: `s_ready` falls the cycle after the second bank commits while the first bank is still unreleased.
- `frame_err` is high for exactly one cycle, on the cycle after the offending accept.

## Configuration
- `FEEDER_BINARIZE_EN` defined:
  - Each bank entry is 1 bit: `s_data >= THRESH`.
  - `dout` is +1 (32'sd1) for a 1 and -1 (32'hFFFFFFFF) for a 0.
- Undefined:
  - Entries are `PIX_W` bits.
  - `dout` is the zero-extended pixel, and `THRESH` is unused.

## Test plan
- Single frame: stream 784 pixels with value `i%256`, `s_last` on pixel 783, and `din_ready` held high.
  - `start` rises, and 784 words follow in order.
  - With `BINARIZE_EN`, words 0..127 are -1 and 128..255 are +1, repeating.
  - `conv1_done` drops `start` and sets `frames_sent=1`.
- Back-to-back: push 3 frames with `conv1_done` withheld.
  - `s_ready` goes low after frame 2.
  - Frame 3 stalls until the first `conv1_done`, then completes.
  - Frames emerge in order.
- Gappy `din_ready` (high every other cycle): `dout` changes only after `din_ready` edges, no word is skipped or repeated, and 784 words arrive in 1568 cycles.
- Early `s_last` at pixel 500: `frame_err` is a 1-cycle pulse, no `start` results, and the next 784-pixel frame streams correctly.
- Missing `s_last` on pixel 783: `frame_err` pulses, and the frame is still committed and streamed.
- Reset asserted mid-`R_STREAM` at word 300: `start=0`, `dout=0` and `s_ready=1` immediately. After release, a fresh frame streams from word 0.

Source files
------------

// File: rtl/image_frame_feeder.sv
// Ping-pong frame buffer feeding a CNN: host stream in, paced words out.
// Ports: clk/rst, s_valid/s_ready/s_data/s_last in; din_ready/dout/start/
// conv1_done to network; frame_err pulse; frames_sent count.
// Option: define FEEDER_BINARIZE_EN to store 1-bit entries (+1/-1 words).
module image_frame_feeder #(
  parameter int PIX_W     = 8,
  parameter int FRAME_LEN = 784,
  parameter int DOUT_W    = 32,
  parameter int THRESH    = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PIX_W-1:0]         s_data,
  input  logic                     s_last,
  input  logic                     din_ready,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     start,
  input  logic                     conv1_done,
  output logic                     frame_err,
  output logic [15:0]              frames_sent
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

`ifdef FEEDER_BINARIZE_EN
  localparam int EW = 1;
`else
  localparam int EW = PIX_W;
`endif

  typedef enum logic [1:0] {
    R_IDLE,
    R_STREAM,
    R_WAIT
  } rstate_t;

  logic [EW-1:0]     r_bank0 [FRAME_LEN];
  logic [EW-1:0]     r_bank1 [FRAME_LEN];
  logic [1:0]        r_full;
  logic              r_wb;
  logic              r_rb;
  logic [CW-1:0]     r_wcnt;
  logic [CW-1:0]     r_rcnt;
  logic              r_frame_err;
  rstate_t           r_state;
  logic              r_start;
  logic [DOUT_W-1:0] r_dout;
  logic [15:0]       r_sent;

  logic              w_accept;
  logic              w_wlast;
  logic              w_commit;
  logic              w_err;
  logic              w_release;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;
  logic [EW-1:0]     w_entry;
  logic [EW-1:0]     w_rd_entry;
  logic [DOUT_W-1:0] w_word;
  logic              w_unused_thresh;

  assign s_ready     = !r_full[r_wb];
  assign frame_err   = r_frame_err;
  assign start       = r_start;
  assign dout        = r_dout;
  assign frames_sent = r_sent;

  assign w_accept  = s_valid && s_ready;
  assign w_wlast   = (r_wcnt == LAST);
  assign w_commit  = w_accept && w_wlast;
  // Error on a full-length frame without s_last, or s_last too early.
  assign w_err     = w_accept && (w_wlast ? !s_last : s_last);
  assign w_release = conv1_done &&
                     (r_state == R_STREAM || r_state == R_WAIT);

  assign w_set = w_commit  ? (2'b01 << r_wb) : 2'b00;
  assign w_clr = w_release ? (2'b01 << r_rb) : 2'b00;

  assign w_rd_entry = r_rb ? r_bank1[r_rcnt] : r_bank0[r_rcnt];

`ifdef FEEDER_BINARIZE_EN
  assign w_entry = (s_data >= PIX_W'(THRESH));
  assign w_word  = w_rd_entry[0] ? {{(DOUT_W-1){1'b0}}, 1'b1}
                                 : {DOUT_W{1'b1}};
`else
  assign w_entry = s_data;
  assign w_word  = {{(DOUT_W-EW){1'b0}}, w_rd_entry};
`endif

  assign w_unused_thresh = ^32'(THRESH);

  // Storage has no reset; validity lives in r_full.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_wb) r_bank1[r_wcnt] <= w_entry;
      else      r_bank0[r_wcnt] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt      <= '0;
      r_wb        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_accept) begin
        if (w_wlast) begin
          r_wcnt <= '0;
          r_wb   <= ~r_wb;
        end else if (s_last) begin
          r_wcnt <= '0;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
    end
  end

  // Commit and release always hit different banks, so set/clear compose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_full <= 2'b00;
    else     r_full <= (r_full | w_set) & ~w_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_rcnt  <= '0;
      r_rb    <= 1'b0;
      r_start <= 1'b0;
      r_dout  <= '0;
      r_sent  <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (r_full[r_rb]) begin
            r_start <= 1'b1;
            r_rcnt  <= '0;
            r_state <= R_STREAM;
          end
        end
        R_STREAM: begin
          // Early release drops the unread remainder.
          if (conv1_done) begin
            r_start <= 1'b0;
            r_rb    <= ~r_rb;
            r_sent  <= r_sent + 16'd1;
            r_state <= R_IDLE;
          end else if (din_ready) begin
            r_dout <= w_word;
            r_rcnt <= r_rcnt + 1'b1;
            if (r_rcnt == LAST) r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (din_ready) r_dout <= '0;
          if (conv1_done) begin
            r_start <= 1'b0;
            r_rb    <= ~r_rb;
            r_sent  <= r_sent + 16'd1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
